// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between the execute stage (port 0) and
// the address/branch unit (port 1). One operation is in flight at a time:
// accept in IDLE, evaluate in EXEC, hand the captured result back in RESP.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins a tie and
// no round-robin pointer is kept. Default build arbitrates round-robin.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [CTRL_W-1:0]  req0_ctrl,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [CTRL_W-1:0]  req1_ctrl,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic [2:0]         rsp_flags,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   grant0, grant1;
  logic   accept;

  // operand selection for the accept stage; operand 1 is a signed quantity
  logic signed [DATA_W-1:0] a_p0;
  logic        [DATA_W-1:0] b_p0;
  logic        [SHAMT_W-1:0] shamt_p0;
  logic        [CTRL_W-1:0]  ctrl_p0;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // fixed priority: port 0 wins whenever it is requesting
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`else
  logic last_grant;

  // round-robin: a tie goes to the port that did not win the previous accept
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  // pointer moves only when an operation is actually accepted
  always_ff @(posedge clk) begin
    if (rst)                          last_grant <= 1'b1;
    else if (state == IDLE && accept) last_grant <= grant1;
  end
`endif

  // payload mux toward the drive registers, chosen by the winning port
  always_comb begin
    a_p0     = grant1 ? $signed(req1_a) : $signed(req0_a);
    b_p0     = grant1 ? req1_b     : req0_b;
    shamt_p0 = grant1 ? req1_shamt : req0_shamt;
    ctrl_p0  = grant1 ? req1_ctrl  : req0_ctrl;
  end

  // next-state and handshake outputs; request readies are masked during reset
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        accept     = grant0 || grant1;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // accept stage -> drive registers; EXEC stage -> response register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_shamt  <= '0;
      alu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
    end else begin
      if (state == IDLE && accept) begin
        owner     <= grant1;
        alu_in1   <= a_p0;
        alu_in2   <= b_p0;
        alu_shamt <= shamt_p0;
        alu_ctrl  <= ctrl_p0;
      end
      if (state == EXEC) begin
        rsp_result <= alu_out;
        rsp_flags  <= {alu_negative, alu_zero, alu_carry};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed bench for alu_arbiter. A small
// ALU is attached to the drive outputs; a transaction-level model predicts
// grants, latency, readies and returned results every cycle.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_ctrl;
  logic        alu_negative, alu_zero, alu_carry;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // reference ALU: returns {result, negative, zero, carry}
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input logic [3:0] ct);
    logic [31:0] r;
    logic        c;
    c = 1'b0;
    case (ct)
      4'd0: {c, r} = {1'b0, a} + {1'b0, b};
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = $signed(a) >>> sh;
      default: r = a;
    endcase
    return {r, r[31], (r == 32'd0), c};
  endfunction

  always_comb {alu_out, alu_negative, alu_zero, alu_carry} = alu_f(alu_in1, alu_in2, alu_shamt, alu_ctrl);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // transaction-level model
  bit          m_busy = 1'b0;
  int          m_age, m_own, m_last;
  logic [31:0] m_in1, m_in2, m_res;
  logic [4:0]  m_sh;
  logic [3:0]  m_ct;
  logic [2:0]  m_flg;
  bit          acc_now;
  int          gq[$];

  function automatic int mgrant();
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 1) ? 0 : 1;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic check_cycle();
    int g;
    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      return;
    end
    if (!m_busy) begin
      g = mgrant();
      chk("req0_ready", req0_ready, (g == 0));
      chk("req1_ready", req1_ready, (g == 1));
      chk("idle_rsp0_valid", rsp0_valid, 0);
      chk("idle_rsp1_valid", rsp1_valid, 0);
    end else begin
      chk("busy_req0_ready", req0_ready, 0);
      chk("busy_req1_ready", req1_ready, 0);
      chk("rsp0_valid", rsp0_valid, (m_age >= 2 && m_own == 0));
      chk("rsp1_valid", rsp1_valid, (m_age >= 2 && m_own == 1));
    end
    chk("alu_in1", alu_in1, m_in1);
    chk("alu_in2", alu_in2, m_in2);
    chk("alu_shamt", alu_shamt, m_sh);
    chk("alu_ctrl", alu_ctrl, m_ct);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_flags", rsp_flags, m_flg);
  endtask

  // advance the model across the coming edge, using the inputs now applied
  task automatic model_update();
    int g;
    acc_now = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_last = 1;
      m_in1 = 0; m_in2 = 0; m_sh = 0; m_ct = 0; m_res = 0; m_flg = 0;
    end else if (!m_busy) begin
      g = mgrant();
      if (g >= 0) begin
        m_busy = 1'b1; m_age = 1; m_own = g; m_last = g; acc_now = 1'b1;
        m_in1 = g ? req1_a : req0_a;
        m_in2 = g ? req1_b : req0_b;
        m_sh  = g ? req1_shamt : req0_shamt;
        m_ct  = g ? req1_ctrl : req0_ctrl;
        gq.push_back(g);
      end
    end else if (m_age == 1) begin
      m_age = 2;
      {m_res, m_flg} = alu_f(m_in1, m_in2, m_sh, m_ct);
    end else if (m_own == 0 ? rsp0_ready : rsp1_ready) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] ct);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_shamt = sh; req0_ctrl = ct;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_shamt = sh; req1_ctrl = ct;
    end
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_now && n < 20);
    if (!acc_now) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [3:0] ct);
    set_req(p, a, b, sh, ct);
    wait_accept("send");
    if (acc_now) chk("send_port", gq[gq.size()-1], p);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  initial begin
    int gs;
    logic [31:0] pa;
    rst = 1'b1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_shamt = 0; req0_ctrl = 0;
    req1_a = 0; req1_b = 0; req1_shamt = 0; req1_ctrl = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // basic add on port 0
    send(0, 32'd5, 32'd7, 5'd0, 4'd0);
    chk("t1_alu_ctrl", alu_ctrl, 0);
    step();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_flags", rsp_flags, 3'b000);
    repeat (2) step();

    // wrap-around add on port 1
    send(1, 32'hFFFFFFFF, 32'd1, 5'd0, 4'd0);
    step();
    chk("t2_rsp1_valid", rsp1_valid, 1);
    chk("t2_rsp0_valid", rsp0_valid, 0);
    chk("t2_result", rsp_result, 32'd0);
    chk("t2_flags", rsp_flags, 3'b011);
    repeat (2) step();

    // continuous tie for four operations
    gs = gq.size();
    set_req(0, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 8)));
    set_req(1, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 8)));
    for (int i = 0; i < 60 && gq.size() < gs + 4; i++) step();
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", gq.size() - gs, 4);
    if (gq.size() >= gs + 4) begin
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk($sformatf("grant_%0d", k), gq[gs+k], 0);
`else
        chk($sformatf("grant_%0d", k), gq[gs+k], k % 2);
`endif
      end
    end
    repeat (4) step();

    // arithmetic shift under response backpressure, port 1 waiting
    rsp0_ready = 0;
    set_req(1, $urandom, $urandom, 5'($urandom), 4'd2);
    set_req(0, 32'h80000000, 32'd0, 5'd4, 4'd7);
    wait_accept("t4");
    if (acc_now) chk("t4_port", gq[gq.size()-1], 0);
    req0_valid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rsp0_valid", rsp0_valid, 1);
      chk("t4_result", rsp_result, 32'hF8000000);
      chk("t4_flags", rsp_flags, 3'b100);
      chk("t4_req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    step();
    wait_accept("t4b");
    req1_valid = 0;
    repeat (4) step();

    // reset while in EXEC drops the operation
    send(0, $urandom, $urandom, 5'($urandom), 4'($urandom_range(1, 8)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rsp0_valid", rsp0_valid, 0);
    chk("t5_alu_in1", alu_in1, 0);
    chk("t5_alu_ctrl", alu_ctrl, 0);
    chk("t5_result", rsp_result, 0);
    chk("t5_flags", rsp_flags, 0);
    repeat (3) step();
    set_req(0, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 8)));
    set_req(1, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 8)));
    wait_accept("t5_tie");
    if (acc_now) chk("t5_tie_port", gq[gq.size()-1], 0);
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();

    // payload changing while busy: only the post-handshake payload is taken
    rsp0_ready = 0;
    send(0, 32'd100, 32'd23, 5'd0, 4'd1);
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      pa = $urandom;
      set_req(0, pa, $urandom, 5'($urandom), 4'($urandom_range(0, 8)));
      step();
    end
    chk("t6_result", rsp_result, 32'd77);
    rsp0_ready = 1;
    wait_accept("t6b");
    chk("t6_second_in1", alu_in1, pa);
    req0_valid = 0;
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      if (!req0_valid && ($urandom_range(0, 2) == 0))
        set_req(0, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 9)));
      if (!req1_valid && ($urandom_range(0, 2) == 0))
        set_req(1, $urandom, $urandom, 5'($urandom), 4'($urandom_range(0, 9)));
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      step();
      if (acc_now) begin
        if (gq[gq.size()-1] == 0) req0_valid = 0; else req1_valid = 0;
      end
    end
    rst = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch unit. Each request carries operands, shift amount and a 4-bit ALU control code. The block arbitrates round-robin and drives the ALU from registered operands. It captures result and flags into a response register and returns them to the winning port over a valid/ready handshake. Only one operation is in flight at a time.

## Interface
- `DATA_W`, 32, operand/result width; must match the ALU.
- `CTRL_W`, 4, ALU control code width.
- `SHAMT_W`, 5, shift amount width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_a` / `req1_a`  in  DATA_W  operand 1, signed.
- `req0_b` / `req1_b`  in  DATA_W  operand 2.
- `req0_shamt` / `req1_shamt`  in  SHAMT_W  shift amount.
- `req0_ctrl` / `req1_ctrl`  in  CTRL_W  ALU control code, passed through unmodified.
- `rsp0_valid` / `rsp1_valid`  out  1  response available.
- `rsp0_ready` / `rsp1_ready`  in  1  response consumed.
- `rsp_result`  out  DATA_W  shared result bus; qualified by `rsp0_valid`/`rsp1_valid`.
- `rsp_flags`  out  3  `{negative, zero, carry}` captured with the result.
- `alu_in1`, `alu_in2`  out  DATA_W  drive ALU operand inputs.
- `alu_shamt`  out  SHAMT_W  drives ALU shift amount.
- `alu_ctrl`  out  CTRL_W  drives ALU control signal.
- `alu_out`  in  DATA_W  ALU result.
- `alu_negative`, `alu_zero`, `alu_carry`  in  1  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE:
  - `reqN_ready` = (state==IDLE) and (port N granted).
  - Grant rule: if only one port is valid, grant that port. If both are valid, grant the port that did not win last. `last_grant` resets to 1, so port 0 wins the first tie.
  - On accept: register a, b, shamt and ctrl into the `alu_*` drive registers, record `owner`, update `last_grant`, and go to EXEC.
- EXEC: the ALU evaluates combinationally from the drive registers. At the end of the cycle, capture `alu_out` and `{alu_negative, alu_zero, alu_carry}` into `rsp_result`/`rsp_flags`, then go to RESP.
- RESP:
  - `rsp<owner>_valid` = 1; the other response valid stays 0.
  - Hold result and flags stable until `rsp<owner>_ready`. On that handshake, go to IDLE.
  - `rsp<non-owner>_ready` is ignored.
- Both request readies are 0 in EXEC and RESP. Requesters must hold valid and payload until accepted.
- The control code is not decoded. Carry is meaningful only for the add code (4'd0); it is passed through for all codes.
- The drive registers hold their last values in IDLE. No new ALU activity occurs without an accept.

## Timing
- Reset values: all `req*_ready`=0 on the reset cycle, all `rsp*_valid`=0, `rsp_result`=0, `rsp_flags`=3'b000, `alu_in1`/`alu_in2`/`alu_shamt`/`alu_ctrl`=0, `last_grant`=1, `owner`=0.
- Latency: accept at edge T. `rsp_valid` is high from T+2, for any ALU code.
- Throughput: at most one operation per 3 cycles (IDLE→EXEC→RESP with ready=1 in the first RESP cycle). The next accept is possible in the cycle after the response handshake.
- Response backpressure: RESP lasts until ready. Result and flags remain unchanged during stalls.
- Request valid asserted while busy: it is simply not accepted. The round-robin pointer does not advance.
- Reset mid-EXEC or mid-RESP: the in-flight operation is dropped, no response is issued, and all outputs return to their reset values at the next edge.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Port 0 always wins when both ports are valid, and `last_grant` is not implemented.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then port0 requests a=32'd5, b=32'd7, ctrl=4'd0 with rsp0_ready=1 → `alu_ctrl`=0 at T+1; at T+2 `rsp0_valid`=1, `rsp_result`=12, flags=3'b000; rsp1_valid stays 0.
- Port1 requests a=32'hFFFFFFFF, b=32'd1, ctrl=4'd0 → `rsp_result`=0, flags=3'b011 (zero, carry), delivered on port1 only.
- Both ports valid continuously for 4 operations → grants go 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` defined → grants go 0,0,0,0.
- Port0 op a=32'h80000000, b=0, shamt=4, ctrl=4'd7, with rsp0_ready=0 for 5 cycles → `rsp0_valid` stays high and `rsp_result`=32'hF8000000, flags=3'b100, stable throughout; `req1_ready` stays 0 the whole time.
- Accept a port0 op, then assert `rst` in the EXEC cycle → no `rsp0_valid`; all outputs are 0 at the next edge; the next tie is won by port 0.
- Port0 valid with payload changing while busy → only the first payload is executed; the second is accepted only after the response handshake.
